// File: rtl/out_port_uart_tx.sv
// Memory-mapped UART transmitter: CPU byte writes go into a small FIFO and are sent as 8N1 frames on TxD.
// Optional build macro PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module out_port_uart_tx #(
    parameter logic [7:0] PORT_ADDR    = 8'hF4,
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 4,
    localparam int        CW           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          WrEn,
    input  logic [7:0]    Address,
    input  logic [7:0]    Datain,
    output logic          TxD,
    output logic          Busy,
    output logic          Full,
    output logic          Empty,
    output logic [CW-1:0] Count,
    output logic          Overflow,
    output logic [2:0]    fsm_state
);

    localparam int         AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int         TW        = $clog2(CLKS_PER_BIT);
    localparam logic [7:0] CTRL_ADDR = PORT_ADDR + 8'd1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t          state;
    logic            tx;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
`ifdef PARITY_EN
    logic            parity;
`endif

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic            ovf;

    logic            is_data;
    logic            is_ctrl;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;
    logic            clr;
    logic            tick_last;

    assign is_data   = WrEn && (Address == PORT_ADDR);
    assign is_ctrl   = WrEn && (Address == CTRL_ADDR);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign push      = is_data && !full;
    assign drop      = is_data && full;
    assign clr       = is_ctrl && Datain[0];
    // The transmitter only takes a byte while idle, so a pop always starts a frame.
    assign pop       = (state == IDLE) && (count != '0);
    assign tick_last = (timer == LAST_TICK);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A clear on the control address beats a simultaneous drop.
            if (clr)
                ovf <= 1'b0;
            else if (drop)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= Datain;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx    <= 1'b1;
                    timer <= '0;
                    if (pop) begin
                        shift  <= mem[rptr];
`ifdef PARITY_EN
                        parity <= ^mem[rptr];
`endif
                        state  <= START;
                        tx     <= 1'b0;
                    end
                end
                START: begin
                    if (tick_last) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_last) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef PARITY_EN
                            state <= PARITY;
                            tx    <= parity;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (tick_last) begin
                        timer <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (tick_last) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    timer <= '0;
                end
            endcase
        end
    end

    assign TxD       = tx;
    assign Count     = count;
    assign Full      = full;
    assign Empty     = (count == '0);
    assign Overflow  = ovf;
    assign Busy      = (state != IDLE) || (count != '0);
    assign fsm_state = state;

endmodule

// File: doc/out_port_uart_tx.md
Name: out_port_uart_tx

Overview:
Memory-mapped serial output stage downstream of the CPU output-port write path. It captures CPU byte writes to its port address into a small FIFO and shifts each byte out on TxD as an 8N1 asynchronous serial frame. Status outputs let the CPU throttle writes without polling a wire directly.

Parameters:
PORT_ADDR, 8'hF4, data write address; PORT_ADDR+1 is the control address
CLKS_PER_BIT, 16, clk cycles per serial bit, >=2
FIFO_DEPTH, 4, FIFO entries, power of 2, >=2

Ports:
clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
WrEn  input  1  CPU write strobe, one cycle per write
Address  input  8  CPU address bus
Datain  input  8  CPU write data
TxD  output  1  serial line, idle high
Busy  output  1  high while a frame is on the line or the FIFO is non-empty
Full  output  1  FIFO holds FIFO_DEPTH entries
Empty  output  1  FIFO holds 0 entries
Count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
Overflow  output  1  sticky flag: a data write was dropped

Behaviour:
- Reset (async, active-high) and its effects: TxD=1, Busy=0, Full=0, Empty=1, Count=0, Overflow=0. FIFO pointers clear and FSM=IDLE. Reset asserted mid-frame drives TxD high immediately and discards the FIFO contents.
- Push: accepted at a rising edge when WrEn=1, Address==PORT_ADDR and Full=0 (Full as sampled before that edge). Count increments after the edge.
- Dropped write: if WrEn=1, Address==PORT_ADDR and Full=1, the data is discarded and Overflow is set. This holds even if a pop occurs on the same edge.
- Control write: WrEn=1, Address==PORT_ADDR+1, Datain[0]=1 clears Overflow. If a drop and a clear coincide, the clear wins. Datain[7:1] are ignored.
- Other addresses are ignored.
- Simultaneous push and pop (FIFO not full): both occur and Count is unchanged.
- FSM states and transitions:
  - IDLE: TxD=1. If Empty=0, pop the head into the shift register and go to START.
  - START: TxD=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles, then go to STOP.
  - STOP: TxD=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: a write accepted at edge E0 sets Count=1 after E0. With the FSM in IDLE, the pop happens at E1 and TxD falls after E1. Frame length is 10*CLKS_PER_BIT cycles.
- Back-to-back frames: STOP->IDLE costs one cycle, so TxD is high for CLKS_PER_BIT+1 cycles between frames.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps. The bit index counts 0..7. FIFO pointers wrap modulo FIFO_DEPTH.
- Busy = (FSM != IDLE) | ~Empty. All outputs are registered or derived from registers only.

Optional Feature:
PARITY_EN defined:
- FSM adds a PARITY state between DATA and STOP.
- TxD carries the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
- Frame length becomes 11*CLKS_PER_BIT cycles.

PARITY_EN undefined:
- No PARITY state.
- Frame is exactly 8N1 as described in Behaviour.

Test Plan:
- Reset sequence: assert Reset mid-idle, then mid-frame -> TxD=1 immediately, Count=0, Empty=1, Overflow=0, no further TxD activity.
- Single write, CLKS_PER_BIT=4: write 8'hA5 to 8'hF4 -> TxD low 1 cycle after the accept edge. Bits sampled every 4 cycles read 0,1,0,1,0,0,1,0,1 then stop=1. Busy falls after STOP ends.
- FIFO fill and overflow, FIFO_DEPTH=4: 6 back-to-back writes 8'h01..8'h06 while frame 1 is active -> bytes 01..05 transmitted in order, 06 dropped. Full observed, Overflow=1. Write 8'h01 to 8'hF5 -> Overflow=0.
- Address filtering: writes to 8'hF3, 8'hF6, and 8'hF4 with WrEn=0 -> Count stays 0, TxD stays 1.
- Simultaneous push and pop: FIFO holds 1 entry, FSM enters IDLE, write 8'h3C on the same edge as the pop -> Count remains 1, and 8'h3C is sent next.
- PARITY_EN build: send 8'h07 -> parity bit=1 between bit7 and stop. Send 8'h03 -> parity bit=0. Frame = 44 cycles at CLKS_PER_BIT=4.
